// File: rtl/fir_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fir_seq_ctrl
// Purpose  : Job sequencer for one FIR tile chain. Issues the tile
//            configuration pulse, loads taps with a descending index, streams
//            input samples through a stall-aware output register and appends
//            zero samples to flush the tap delay line.
// Revision : 1.0 - initial release
// ============================================================================
module fir_seq_ctrl #(
    parameter int NUM_TAPS_MAX = 16,
    parameter int DATA_W       = 16,
    parameter int CNT_W        = 16,
    parameter int CFG_GAP      = 4,
    parameter int TAP_W        = $clog2(NUM_TAPS_MAX) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    // job descriptor
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [TAP_W-1:0]      cfg_num,
    input  logic [1:0]            cfg_mode,
    input  logic [CNT_W-1:0]      cfg_len,
    // tile configuration
    output logic                  cont_valid,
    output logic [TAP_W-1:0]      cont_num,
    output logic [1:0]            cont_mode,
    // tap source and tap-load bus
    input  logic                  tap_s_valid,
    output logic                  tap_s_ready,
    input  logic [2*DATA_W-1:0]   tap_s_data,
    output logic                  tap_valid,
    output logic [2*DATA_W-1:0]   tap_data,
    output logic [TAP_W-1:0]      tap_count,
    // sample source and first-tile sample path
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [2*DATA_W-1:0]   s_data,
    input  logic                  tile_ready,
    output logic                  smp_valid,
    output logic [2*DATA_W-1:0]   smp_data,
    // status
    output logic                  busy,
    output logic                  done
);

    localparam int GAP_W = (CFG_GAP > 1) ? $clog2(CFG_GAP) : 1;

    localparam logic [TAP_W-1:0] c_tap_one  = TAP_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [GAP_W-1:0] c_gap_one  = GAP_W'(1);
    localparam logic [GAP_W-1:0] c_gap_last = GAP_W'((CFG_GAP > 0) ? CFG_GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CONFIG = 3'd1,
        S_GAP    = 3'd2,
        S_LOAD   = 3'd3,
        S_STREAM = 3'd4,
        S_FLUSH  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t               r_state;
    logic [TAP_W-1:0]     r_num;
    logic [1:0]           r_mode;
    logic [TAP_W-1:0]     r_tap_rem;   // taps left to load, then flush zeros left
    logic [CNT_W-1:0]     r_len_rem;   // input samples left to accept
    logic [GAP_W-1:0]     r_gap;
    logic                 r_cont_valid;
    logic                 r_tap_valid;
    logic [2*DATA_W-1:0]  r_tap_data;
    logic [TAP_W-1:0]     r_tap_count;
    logic                 r_smp_valid;
    logic [2*DATA_W-1:0]  r_smp_data;
    logic                 r_done;

    logic [TAP_W-1:0]     w_num;
    logic [CNT_W-1:0]     w_len;

    // A zero tap count or zero length is run as a single tap / single sample
    assign w_num = (cfg_num == '0) ? c_tap_one : cfg_num;
    assign w_len = (cfg_len == '0) ? c_cnt_one : cfg_len;

    // Handshake readies and status decode straight from the state register
    assign cfg_ready   = (r_state == S_IDLE);
    assign tap_s_ready = (r_state == S_LOAD);
    assign s_ready     = (r_state == S_STREAM) && tile_ready;
    assign busy        = (r_state != S_IDLE);

    assign cont_valid  = r_cont_valid;
    assign cont_num    = r_num;
    assign cont_mode   = r_mode;
    assign tap_valid   = r_tap_valid;
    assign tap_data    = r_tap_data;
    assign tap_count   = r_tap_count;
    assign smp_valid   = r_smp_valid;
    assign smp_data    = r_smp_data;
    assign done        = r_done;

    // Job sequencer with all tile-facing outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_num        <= '0;
            r_mode       <= '0;
            r_tap_rem    <= '0;
            r_len_rem    <= '0;
            r_gap        <= '0;
            r_cont_valid <= 1'b0;
            r_tap_valid  <= 1'b0;
            r_tap_data   <= '0;
            r_tap_count  <= '0;
            r_smp_valid  <= 1'b0;
            r_smp_data   <= '0;
            r_done       <= 1'b0;
        end else begin
            r_cont_valid <= 1'b0;
            r_tap_valid  <= 1'b0;
            r_done       <= 1'b0;

            // Outside STREAM/FLUSH the sample register only drains; it never
            // changes while the tile is stalling.
            if (tile_ready) begin
                r_smp_valid <= 1'b0;
                r_smp_data  <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        r_num        <= w_num;
                        r_mode       <= cfg_mode;
                        r_tap_rem    <= w_num;
                        r_len_rem    <= w_len;
                        r_cont_valid <= 1'b1;
                        r_state      <= S_CONFIG;
                    end
                end

                S_CONFIG: begin
                    r_gap   <= '0;
                    r_state <= (CFG_GAP == 0) ? S_LOAD : S_GAP;
                end

                S_GAP: begin
                    if (r_gap == c_gap_last) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_gap <= r_gap + c_gap_one;
                    end
                end

                S_LOAD: begin
                    // Source bubbles leave the count untouched
                    if (tap_s_valid) begin
                        r_tap_valid <= 1'b1;
                        r_tap_data  <= tap_s_data;
                        r_tap_count <= r_tap_rem - c_tap_one;
                        r_tap_rem   <= r_tap_rem - c_tap_one;
                        if (r_tap_rem == c_tap_one) begin
                            r_state <= S_STREAM;
                        end
                    end
                end

                S_STREAM: begin
                    if (tile_ready) begin
                        r_smp_valid <= s_valid;
                        r_smp_data  <= s_data;
                        if (s_valid) begin
                            r_len_rem <= r_len_rem - c_cnt_one;
                            if (r_len_rem == c_cnt_one) begin
                                // Delay line needs num-1 zeros behind the last sample
                                r_tap_rem <= r_num - c_tap_one;
                                if (r_num == c_tap_one) begin
                                    r_done  <= 1'b1;
                                    r_state <= S_DONE;
                                end else begin
                                    r_state <= S_FLUSH;
                                end
                            end
                        end
                    end
                end

                S_FLUSH: begin
                    if (tile_ready) begin
                        r_smp_valid <= 1'b1;
                        r_smp_data  <= '0;
                        r_tap_rem   <= r_tap_rem - c_tap_one;
                        if (r_tap_rem == c_tap_one) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fir_seq_ctrl
// Purpose  : Self-checking bench for fir_seq_ctrl. Expected tap beats and
//            samples are queued when the source side hands them over and
//            popped against what the tile side observes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_seq_ctrl;

    localparam int NUM_TAPS_MAX = 16;
    localparam int DATA_W       = 16;
    localparam int CNT_W        = 16;
    localparam int CFG_GAP      = 4;
    localparam int TAP_W        = $clog2(NUM_TAPS_MAX) + 1;
    localparam int DW2          = 2 * DATA_W;
    localparam int LIMIT        = 3000;
    localparam int OUT_W        = 2 * TAP_W + 2 + 2 * DW2 + 7;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [TAP_W-1:0]   cfg_num = '0;
    logic [1:0]         cfg_mode = '0;
    logic [CNT_W-1:0]   cfg_len = '0;
    logic               cont_valid;
    logic [TAP_W-1:0]   cont_num;
    logic [1:0]         cont_mode;
    logic               tap_s_valid = 1'b0;
    logic               tap_s_ready;
    logic [DW2-1:0]     tap_s_data = '0;
    logic               tap_valid;
    logic [DW2-1:0]     tap_data;
    logic [TAP_W-1:0]   tap_count;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [DW2-1:0]     s_data = '0;
    logic               tile_ready = 1'b1;
    logic               smp_valid;
    logic [DW2-1:0]     smp_data;
    logic               busy;
    logic               done;

    logic [OUT_W-1:0]   all_outs;
    assign all_outs = {cont_valid, cont_num, cont_mode, tap_valid, tap_data, tap_count,
                       smp_valid, smp_data, busy, done, tap_s_ready, s_ready};

    fir_seq_ctrl #(
        .NUM_TAPS_MAX (NUM_TAPS_MAX),
        .DATA_W       (DATA_W),
        .CNT_W        (CNT_W),
        .CFG_GAP      (CFG_GAP),
        .TAP_W        (TAP_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_num     (cfg_num),
        .cfg_mode    (cfg_mode),
        .cfg_len     (cfg_len),
        .cont_valid  (cont_valid),
        .cont_num    (cont_num),
        .cont_mode   (cont_mode),
        .tap_s_valid (tap_s_valid),
        .tap_s_ready (tap_s_ready),
        .tap_s_data  (tap_s_data),
        .tap_valid   (tap_valid),
        .tap_data    (tap_data),
        .tap_count   (tap_count),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .tile_ready  (tile_ready),
        .smp_valid   (smp_valid),
        .smp_data    (smp_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // scoreboard queues: {count, data} for taps, data for samples
    logic [TAP_W+DW2-1:0] exp_tap_q[$];
    logic [TAP_W+DW2-1:0] obs_tap_q[$];
    logic [DW2-1:0]       exp_smp_q[$];
    logic [DW2-1:0]       obs_smp_q[$];

    int cont_cnt, done_cnt, stall_viol, stall_cycles, rdy_busy, early_smp;
    int cont_cyc, first_tap_cyc, hs_cyc, smp_first, smp_last;
    logic [TAP_W-1:0] last_cont_num;
    logic [1:0]       last_cont_mode;
    logic             prev_stall;
    logic             prev_v;
    logic [DW2-1:0]   prev_d;

    function automatic logic [DW2-1:0] tap_word(input int k);
        return {DATA_W'(k + 2), DATA_W'(0)};
    endfunction

    function automatic logic [DW2-1:0] smp_word(input int n);
        return {DATA_W'(n + 1), DATA_W'(3 * (n + 1))};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Tile-side observer: records what the DUT presents, mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (cont_valid) begin
                cont_cnt++;
                cont_cyc       = cyc;
                last_cont_num  = cont_num;
                last_cont_mode = cont_mode;
            end
            if (tap_valid) begin
                obs_tap_q.push_back({tap_count, tap_data});
                if (first_tap_cyc < 0) first_tap_cyc = cyc;
            end
            if (smp_valid && tile_ready) begin
                obs_smp_q.push_back(smp_data);
                if (smp_first < 0) smp_first = cyc;
                smp_last = cyc;
            end
            if (done) done_cnt++;
            if (busy && cfg_ready) rdy_busy++;
            if (prev_stall && (smp_valid !== prev_v || smp_data !== prev_d)) stall_viol++;
            if (smp_valid && !tile_ready) stall_cycles++;
            prev_stall = smp_valid && !tile_ready;
            prev_v     = smp_valid;
            prev_d     = smp_data;
        end
    end

    task automatic clear_stats();
        exp_tap_q.delete();
        obs_tap_q.delete();
        exp_smp_q.delete();
        obs_smp_q.delete();
        cont_cnt = 0; done_cnt = 0; stall_viol = 0; stall_cycles = 0;
        rdy_busy = 0; early_smp = 0; cont_cyc = -1; first_tap_cyc = -1;
        hs_cyc = -1; smp_first = -1; smp_last = -1;
    endtask

    // Drives one job from both source sides; expected beats are queued as
    // the DUT accepts each source word.
    task automatic run_job(input int num, input int len, input logic [1:0] mode,
                           input int tap_gap, input bit tr_toggle, input bit hold_cfg,
                           input int abort_taps, output bit timed_out);
        int  en, el, ti, si, cycles;
        bit  hs, done_seen;
        en = (num == 0) ? 1 : num;
        el = (len == 0) ? 1 : len;
        ti = 0; si = 0; cycles = 0; hs = 0; done_seen = 0; timed_out = 0;
        @(posedge clk); #1;
        cfg_valid = 1'b1; cfg_num = TAP_W'(num); cfg_mode = mode; cfg_len = CNT_W'(len);
        tap_s_valid = 1'b0; s_valid = 1'b0; tile_ready = 1'b1;
        while (1) begin
            @(negedge clk);
            if (!hs && cfg_valid && cfg_ready) begin
                hs = 1; hs_cyc = cyc;
            end
            if (tap_s_valid && tap_s_ready) begin
                exp_tap_q.push_back({TAP_W'(en - 1 - ti), tap_word(ti)});
                ti++;
            end
            if (s_valid && s_ready) begin
                if (ti < en) early_smp++;
                exp_smp_q.push_back(smp_word(si));
                si++;
                if (si == el) for (int k = 0; k < en - 1; k++) exp_smp_q.push_back('0);
            end
            if (done) done_seen = 1;
            cycles++;
            if (abort_taps > 0 && ti >= abort_taps) return;
            if (done_seen) break;
            if (cycles > LIMIT) begin
                timed_out = 1;
                break;
            end
            @(posedge clk); #1;
            if (hs && !hold_cfg) cfg_valid = 1'b0;
            tap_s_valid = hs && (ti < en) && ((tap_gap == 0) || ((cycles % (tap_gap + 1)) == 0));
            tap_s_data  = tap_word(ti);
            s_valid     = hs && (si < el);
            s_data      = smp_word(si);
            tile_ready  = tr_toggle ? ~tile_ready : 1'b1;
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0; tap_s_valid = 1'b0; s_valid = 1'b0; tile_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (all_outs !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        bit to;
        logic [TAP_W+DW2-1:0] et, ot;
        logic [DW2-1:0] es, os;
        int nsmp;
        clear_stats();
        run_job(2, 64, 2'd0, 0, 1'b0, 1'b0, 0, to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b expected 0", to); end
        n_checks++;
        if (cont_cnt !== 1 || last_cont_num !== TAP_W'(2)) begin
            n_fail++; $display("FAIL basic_cont: pulses %0d num %0d expected 1 pulse num 2", cont_cnt, last_cont_num);
        end
        n_checks++;
        if (cont_cyc !== hs_cyc + 1) begin
            n_fail++; $display("FAIL basic_cont_timing: got cycle %0d expected %0d", cont_cyc, hs_cyc + 1);
        end
        n_checks++;
        if (first_tap_cyc < hs_cyc + 2 + CFG_GAP) begin
            n_fail++; $display("FAIL basic_first_tap: got cycle %0d expected >= %0d", first_tap_cyc, hs_cyc + 2 + CFG_GAP);
        end
        n_checks++;
        if (obs_tap_q.size() !== exp_tap_q.size()) begin
            n_fail++; $display("FAIL basic_tap_beats: got %0d expected %0d", obs_tap_q.size(), exp_tap_q.size());
        end
        while (exp_tap_q.size() > 0 && obs_tap_q.size() > 0) begin
            et = exp_tap_q.pop_front(); ot = obs_tap_q.pop_front();
            n_checks++;
            if (ot !== et) begin n_fail++; $display("FAIL basic_tap: got %h expected %h", ot, et); end
        end
        nsmp = exp_smp_q.size();
        n_checks++;
        if (obs_smp_q.size() !== nsmp) begin
            n_fail++; $display("FAIL basic_smp_count: got %0d expected %0d", obs_smp_q.size(), nsmp);
        end
        while (exp_smp_q.size() > 0 && obs_smp_q.size() > 0) begin
            es = exp_smp_q.pop_front(); os = obs_smp_q.pop_front();
            n_checks++;
            if (os !== es) begin n_fail++; $display("FAIL basic_smp: got %h expected %h", os, es); end
        end
        n_checks++;
        if (smp_last - smp_first !== nsmp - 1) begin
            n_fail++; $display("FAIL basic_throughput: got span %0d expected %0d", smp_last - smp_first, nsmp - 1);
        end
        n_checks++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        bit to;
        logic [DW2-1:0] es, os;
        clear_stats();
        run_job(2, 64, 2'd0, 0, 1'b1, 1'b0, 0, to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got %b expected 0", to); end
        n_checks++;
        if (obs_smp_q.size() !== exp_smp_q.size()) begin
            n_fail++; $display("FAIL bp_smp_count: got %0d expected %0d", obs_smp_q.size(), exp_smp_q.size());
        end
        while (exp_smp_q.size() > 0 && obs_smp_q.size() > 0) begin
            es = exp_smp_q.pop_front(); os = obs_smp_q.pop_front();
            n_checks++;
            if (os !== es) begin n_fail++; $display("FAIL bp_smp: got %h expected %h", os, es); end
        end
        n_checks++;
        if (stall_cycles < 1) begin n_fail++; $display("FAIL bp_stalls: got %0d expected > 0", stall_cycles); end
        n_checks++;
        if (stall_viol !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes expected 0", stall_viol); end
        n_checks++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_tap_bubbles();
        bit to;
        logic [TAP_W+DW2-1:0] et, ot;
        logic [DW2-1:0] es, os;
        clear_stats();
        run_job(4, 8, 2'd1, 2, 1'b0, 1'b0, 0, to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL bub_timeout: got %b expected 0", to); end
        n_checks++;
        if (last_cont_num !== TAP_W'(4) || last_cont_mode !== 2'd1) begin
            n_fail++; $display("FAIL bub_cont: num %0d mode %0d expected 4 1", last_cont_num, last_cont_mode);
        end
        n_checks++;
        if (obs_tap_q.size() !== 4) begin
            n_fail++; $display("FAIL bub_tap_beats: got %0d expected 4", obs_tap_q.size());
        end
        while (exp_tap_q.size() > 0 && obs_tap_q.size() > 0) begin
            et = exp_tap_q.pop_front(); ot = obs_tap_q.pop_front();
            n_checks++;
            if (ot !== et) begin n_fail++; $display("FAIL bub_tap: got %h expected %h", ot, et); end
        end
        n_checks++;
        if (early_smp !== 0) begin n_fail++; $display("FAIL bub_early_stream: got %0d expected 0", early_smp); end
        n_checks++;
        if (obs_smp_q.size() !== exp_smp_q.size()) begin
            n_fail++; $display("FAIL bub_smp_count: got %0d expected %0d", obs_smp_q.size(), exp_smp_q.size());
        end
        while (exp_smp_q.size() > 0 && obs_smp_q.size() > 0) begin
            es = exp_smp_q.pop_front(); os = obs_smp_q.pop_front();
            n_checks++;
            if (os !== es) begin n_fail++; $display("FAIL bub_smp: got %h expected %h", os, es); end
        end
    endtask

    task automatic test_single_tap();
        bit to;
        // second pass uses zero num/len, which must run as one tap, one sample
        for (int pass = 0; pass < 2; pass++) begin
            clear_stats();
            run_job(1 - pass, 1 - pass, 2'd2, 0, 1'b0, 1'b0, 0, to);
            n_checks++;
            if (to !== 1'b0) begin n_fail++; $display("FAIL single%0d_timeout: got %b expected 0", pass, to); end
            n_checks++;
            if (last_cont_num !== TAP_W'(1)) begin
                n_fail++; $display("FAIL single%0d_cont_num: got %0d expected 1", pass, last_cont_num);
            end
            n_checks++;
            if (obs_tap_q.size() !== 1 || obs_tap_q[0] !== {TAP_W'(0), tap_word(0)}) begin
                n_fail++; $display("FAIL single%0d_tap: got %0d beats expected 1 with count 0", pass, obs_tap_q.size());
            end
            n_checks++;
            if (obs_smp_q.size() !== 1 || obs_smp_q[0] !== smp_word(0)) begin
                n_fail++; $display("FAIL single%0d_smp: got %0d samples expected 1 (%h)", pass, obs_smp_q.size(), smp_word(0));
            end
            n_checks++;
            if (done_cnt !== 1) begin n_fail++; $display("FAIL single%0d_done: got %0d expected 1", pass, done_cnt); end
        end
    endtask

    task automatic test_busy_reject();
        bit to;
        clear_stats();
        run_job(2, 16, 2'd3, 0, 1'b0, 1'b1, 0, to);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL busy_timeout: got %b expected 0", to); end
        n_checks++;
        if (cont_cnt !== 1) begin n_fail++; $display("FAIL busy_cont_pulses: got %0d expected 1", cont_cnt); end
        n_checks++;
        if (rdy_busy !== 0) begin n_fail++; $display("FAIL busy_cfg_ready: got %0d busy-ready cycles expected 0", rdy_busy); end
        n_checks++;
        if (obs_smp_q.size() !== 17) begin n_fail++; $display("FAIL busy_smp_count: got %0d expected 17", obs_smp_q.size()); end
        n_checks++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL busy_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_midjob_reset();
        bit to;
        logic [TAP_W+DW2-1:0] et, ot;
        logic [DW2-1:0] es, os;
        clear_stats();
        run_job(4, 8, 2'd0, 0, 1'b0, 1'b0, 2, to);
        #2;
        rst = 1'b1;
        cfg_valid = 1'b0; tap_s_valid = 1'b0; s_valid = 1'b0; tile_ready = 1'b1;
        #1;
        n_checks++;
        if (all_outs !== '0 || cfg_ready !== 1'b1) begin
            n_fail++; $display("FAIL mrst_async: outs %h ready %b expected 0 and 1", all_outs, cfg_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (all_outs !== '0) begin n_fail++; $display("FAIL mrst_next_edge: got %h expected 0", all_outs); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt !== 0) begin n_fail++; $display("FAIL mrst_no_done: got %0d expected 0", done_cnt); end
        clear_stats();
        run_job(3, 10, 2'd1, 0, 1'b0, 1'b0, 0, to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL mrst_timeout: got %b expected 0", to); end
        n_checks++;
        if (obs_tap_q.size() !== 3) begin n_fail++; $display("FAIL mrst_tap_beats: got %0d expected 3", obs_tap_q.size()); end
        while (exp_tap_q.size() > 0 && obs_tap_q.size() > 0) begin
            et = exp_tap_q.pop_front(); ot = obs_tap_q.pop_front();
            n_checks++;
            if (ot !== et) begin n_fail++; $display("FAIL mrst_tap: got %h expected %h", ot, et); end
        end
        n_checks++;
        if (obs_smp_q.size() !== exp_smp_q.size()) begin
            n_fail++; $display("FAIL mrst_smp_count: got %0d expected %0d", obs_smp_q.size(), exp_smp_q.size());
        end
        while (exp_smp_q.size() > 0 && obs_smp_q.size() > 0) begin
            es = exp_smp_q.pop_front(); os = obs_smp_q.pop_front();
            n_checks++;
            if (os !== es) begin n_fail++; $display("FAIL mrst_smp: got %h expected %h", os, es); end
        end
        n_checks++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL mrst_done: got %0d expected 1", done_cnt); end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_basic();
        test_backpressure();
        test_tap_bubbles();
        test_single_tap();
        test_busy_reject();
        test_midjob_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_seq_ctrl.md
# fir_seq_ctrl

Sequencing controller for one FIR tile chain. It accepts a job descriptor (tap count, mode, sample count) and issues the one-cycle configuration pulse to the tile. It then loads taps over the tap-load bus with a descending count, streams input samples into the first tile with stall-aware registering, and appends zero samples to flush the tap delay line before signalling done. It sits between the accelerator front end and the first FIR tile, replacing hand-driven configuration and tap loading.

## Interface
- NUM_TAPS_MAX, 16: maximum taps per job; TAP_W = $clog2(NUM_TAPS_MAX)+1.
- DATA_W, 16: width of each real/imag component.
- CNT_W, 16: sample-count width.
- CFG_GAP, 4: idle cycles between the config pulse and the first tap beat.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_valid / cfg_ready  in/out  1  job handshake.
- cfg_num  in  TAP_W  tap count, 1..NUM_TAPS_MAX.
- cfg_mode  in  2  filter mode, passed to the tile.
- cfg_len  in  CNT_W  number of input samples, ≥1.
- cont_valid  out  1  one-cycle config pulse to the tile.
- cont_num  out  TAP_W  latched cfg_num.
- cont_mode  out  2  latched cfg_mode.
- tap_s_valid / tap_s_ready  in/out  1  tap source handshake.
- tap_s_data  in  2*DATA_W  {real, imag} coefficient.
- tap_valid  out  1  tap-load beat to the tile.
- tap_data  out  2*DATA_W  registered coefficient.
- tap_count  out  TAP_W  tap index, descending num-1..0.
- s_valid / s_ready  in/out  1  input sample handshake.
- s_data  in  2*DATA_W  {real, imag} sample.
- tile_ready  in  1  tile accepts the output register this cycle.
- smp_valid / smp_data  out  1 / 2*DATA_W  sample to the first tile.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at job end.

## Operation
- FSM states: IDLE, CONFIG, GAP, LOAD, STREAM, FLUSH, DONE.
- IDLE:
  - cfg_ready=1; on cfg_valid, latch num/mode/len and go to CONFIG.
  - cfg_num=0 is treated as 1; cfg_len=0 is treated as 1.
- CONFIG: cont_valid=1 for exactly one cycle, then GAP.
- GAP: counts CFG_GAP cycles, then LOAD. With CFG_GAP=0, go straight to LOAD.
- LOAD:
  - tap_s_ready=1.
  - Each accepted beat registers tap_valid=1, tap_data=tap_s_data, tap_count=remaining-1.
  - The first beat carries num-1; the beat carrying 0 moves to STREAM.
  - Source bubbles yield tap_valid=0 with no count change.
- STREAM:
  - Pipeline register with s_ready=tile_ready.
  - When tile_ready=1, the register loads s_valid/s_data; when tile_ready=0, it holds.
  - A transfer occurs on a cycle with smp_valid & tile_ready.
  - Acceptance of sample number cfg_len moves to FLUSH.
- FLUSH:
  - Issues num-1 zero samples (valid=1, data=0) under the same tile_ready stall rule.
  - With num=1, goes directly to DONE.
  - s_ready=0.
- DONE: done=1 for one cycle, then IDLE.
- cont_num/cont_mode hold the latched values until the next job.

## Timing
- Reset (async): state IDLE, all counters 0, every output 0 (cont_*, tap_*, smp_*, busy, done, tap_s_ready, s_ready), except cfg_ready=1.
- Config pulse: cont_valid rises the cycle after the cfg handshake.
- First tap: tap_valid appears no earlier than 2+CFG_GAP cycles after the cfg handshake. Each tap has one-cycle registered latency from source acceptance.
- Sample path: 1-cycle latency when unstalled. Throughput is one sample/cycle while tile_ready=1.
- Stall: with tile_ready low, smp_valid/smp_data remain stable; no sample is lost or duplicated.
- Last tap / last sample: the final tap beat (count 0) and the last accepted sample both occur in the same cycle as the state transition. No idle cycle is inserted before the flush samples.
- New jobs: cfg_valid outside IDLE is ignored (cfg_ready=0); the job is accepted only after returning to IDLE.
- Minimum job duration: done precedes the next cfg acceptance by at least one cycle.
- Mid-job reset: immediate return to IDLE with outputs cleared. No done is produced.

## Test plan
- Basic job: num=2, mode=0, len=64; taps {2,0} then {3,0}; samples 1..64, tile_ready=1. Required:
  - one cont_valid pulse with num=2;
  - tap beats count 1 then 0, data 2 then 3;
  - smp_data 1..64 in order;
  - one zero flush sample, then done.
- Backpressure: the basic job with tile_ready toggling 1/0 every cycle → same 64 samples, no duplication, smp_data stable while stalled.
- Tap bubbles: num=4 with tap_s_valid gapped → tap_count 3,2,1,0 exactly once each; STREAM is entered only after count 0.
- Single tap: num=1, len=1 → one tap with count 0, one sample, no flush beat, done.
- Busy rejection: cfg_valid held during STREAM → cfg_ready=0, no second cont_valid until after done.
- Mid-job reset: rst asserted mid-LOAD → all outputs 0 next edge; a new job after release runs correctly.
